// File: rtl/adder_apb_regbank.sv
// APB3 completer register bank for the adder peripheral: operands, START/DONE control,
// captured result, and the strobe interface to the adder's control FSM.
module adder_apb_regbank #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  ACLK,
    input  logic                  ARST,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR,
    output logic                  o_start,
    output logic [DATA_WIDTH-1:0] o_op_a,
    output logic [DATA_WIDTH-1:0] o_op_b,
    input  logic                  i_is_busy,
    input  logic                  i_en_ctrl_write,
    input  logic                  i_rst_start,
    input  logic [DATA_WIDTH-1:0] i_result
);

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_OP_A   = 2'd1;
    localparam logic [1:0] ADDR_OP_B   = 2'd2;
    localparam logic [1:0] ADDR_RESULT = 2'd3;

    logic [1:0]            reg_sel;
    logic                  setup_ph;
    logic                  access_ph;
    logic                  wr_access;
    logic                  wr_commit;
    logic                  unused_paddr;
    logic [DATA_WIDTH-1:0] ctrl_rd;

    logic                  start_q,  start_d;
    logic                  done_q,   done_d;
    logic [DATA_WIDTH-1:0] op_a_q,   op_a_d;
    logic [DATA_WIDTH-1:0] op_b_q,   op_b_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic [DATA_WIDTH-1:0] prdata_q, prdata_d;

    // Only word offsets select a register; the remaining address bits are don't-care.
    assign reg_sel      = PADDR[3:2];
    assign unused_paddr = ^PADDR;

    assign setup_ph  = PSEL & ~PENABLE;
    assign access_ph = PSEL & PENABLE;
    assign wr_access = access_ph & PWRITE;

    // A write lands only when the FSM is idle, not clearing START, and the target is writable.
    assign wr_commit = wr_access & ~i_is_busy & ~i_rst_start & (reg_sel != ADDR_RESULT);

    assign ctrl_rd = {{(DATA_WIDTH-3){1'b0}}, done_q, i_is_busy, start_q};

    always_comb begin
        // NOTE: every next-state signal takes its held value first so no path leaves it unassigned (no latches).
        start_d  = start_q;
        done_d   = done_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        result_d = result_q;
        prdata_d = prdata_q;

        if (wr_commit) begin
            case (reg_sel)
                ADDR_CTRL: begin
                    start_d = PWDATA[0];
                    if (PWDATA[0]) done_d = 1'b0;
                end
                ADDR_OP_A: op_a_d = PWDATA;
                ADDR_OP_B: op_b_d = PWDATA;
                default:   ;
            endcase
        end

        if (i_rst_start) start_d = 1'b0;

        // A completed operation wins over a same-cycle DONE clear from the bus.
        if (i_en_ctrl_write) begin
            result_d = i_result;
            done_d   = 1'b1;
        end

        if (setup_ph && !PWRITE) begin
            case (reg_sel)
                ADDR_CTRL: prdata_d = ctrl_rd;
                ADDR_OP_A: prdata_d = op_a_q;
                ADDR_OP_B: prdata_d = op_b_q;
                default:   prdata_d = result_q;
            endcase
        end
    end

    always_ff @(posedge ACLK) begin
        // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
        if (ARST) begin
            start_q  <= 1'b0;
            done_q   <= 1'b0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            result_q <= '0;
            prdata_q <= '0;
        end else begin
            start_q  <= start_d;
            done_q   <= done_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            result_q <= result_d;
            prdata_q <= prdata_d;
        end
    end

    // The error must match the commit decision made in the same access cycle, so it is combinational.
    assign PSLVERR = wr_access & ~wr_commit & ~ARST;
    assign PREADY  = 1'b1;
    assign PRDATA  = prdata_q;
    assign o_start = start_q;
    assign o_op_a  = op_a_q;
    assign o_op_b  = op_b_q;

endmodule

// File: doc/adder_apb_regbank.md
# adder_apb_regbank

APB3 completer register bank for the adder peripheral. It holds the operands, the START request and the captured result, and exposes them to the bus. It also gives the peripheral's control FSM what it needs: START out, and busy, result-write and start-clear strobes back in. While the FSM reports busy, the bus cannot modify operands or START.

## Interface
Parameters:
- DATA_WIDTH, 32, width of operands, result and PWDATA/PRDATA (≥ 3)
- ADDR_WIDTH, 4, width of PADDR; registers decoded on PADDR[3:2], PADDR[1:0] ignored

Ports:
- ACLK  in  1  clock; all state updates on rising edge
- ARST  in  1  reset, synchronous, active-high
- PSEL  in  1  APB select
- PENABLE  in  1  APB access phase
- PWRITE  in  1  1 = write, 0 = read
- PADDR  in  ADDR_WIDTH  byte address
- PWDATA  in  DATA_WIDTH  write data
- PRDATA  out  DATA_WIDTH  read data, registered
- PREADY  out  1  tied 1, no wait states
- PSLVERR  out  1  error response, valid in access phase
- o_start  out  1  START bit to control FSM
- o_op_a  out  DATA_WIDTH  operand A
- o_op_b  out  DATA_WIDTH  operand B
- i_is_busy  in  1  FSM busy; bus writes rejected while high
- i_en_ctrl_write  in  1  one-cycle strobe: capture i_result
- i_rst_start  in  1  one-cycle strobe: clear START
- i_result  in  DATA_WIDTH  adder result

## Operation
- Register map on PADDR[3:2]:
  - 0 CTRL: bit0 START (RW), bit1 BUSY (RO, = i_is_busy), bit2 DONE (RO). Other bits read 0.
  - 1 OP_A (RW).
  - 2 OP_B (RW).
  - 3 RESULT (RO).
- Setup phase is PSEL & !PENABLE. Access phase is PSEL & PENABLE; every access completes in it (PREADY=1).
- Write commit happens at the access-phase edge, only when all of these hold:
  - i_is_busy=0
  - i_rst_start=0
  - address is CTRL, OP_A or OP_B
- Any other write is dropped with no state change and PSLVERR=1 in its access phase:
  - write to RESULT
  - write while busy
  - write in a cycle where i_rst_start=1
- CTRL write:
  - START ← PWDATA[0]
  - if PWDATA[0]=1, DONE ← 0
  - bits 1 and 2 of PWDATA ignored
- Reads:
  - PRDATA is loaded at the setup-phase edge with the addressed register and held through the access phase.
  - Reads never error and are allowed while busy.
- i_rst_start=1: START ← 0 on the next edge. This overrides any same-cycle bus write to CTRL, which is rejected with PSLVERR.
- i_en_ctrl_write=1: RESULT ← i_result and DONE ← 1 on the next edge.
- o_start = START, o_op_a = OP_A, o_op_b = OP_B (direct register outputs).
- PSLVERR is 0 outside access phases.

## Timing
- Reset values, all 0: START, DONE, OP_A, OP_B, RESULT, PRDATA, PSLVERR, and hence o_start, o_op_a, o_op_b. PREADY = 1.
- ARST asserted mid-transfer aborts it. No register commits, and PSLVERR/PRDATA go to 0 on the next edge.
- Write latency: a committed value is visible on the register outputs the cycle after the access phase.
- Read latency: data captured at the setup edge. A RESULT capture in the same cycle as the setup phase is not reflected; the read returns the prior value.
- START lifecycle:
  - bus writes START=1, o_start=1 from cycle N+1
  - FSM raises i_is_busy
  - i_en_ctrl_write and i_rst_start pulse together
  - START=0 and DONE=1 in the following cycle
- BUSY bit is sampled combinationally from i_is_busy at the read setup edge.
- Back-to-back transfers (setup immediately after access) are supported with no idle cycle.

## Test plan
- After reset, read CTRL, OP_A, OP_B, RESULT → each PRDATA=0, PSLVERR=0; o_start=0.
- Idle FSM: write OP_A=0x0000_0005, OP_B=0x0000_0003, CTRL=0x1 → o_op_a=5, o_op_b=3, o_start=1 the cycle after each access; readback matches, CTRL reads 0x1.
- Full handshake with a modeled control FSM (busy 3 cycles, final cycle pulsing i_en_ctrl_write and i_rst_start with i_result=8):
  - o_start falls one cycle after the pulse.
  - RESULT reads 0x8.
  - CTRL reads 0x4 (DONE=1, START=0, BUSY=0).
- i_is_busy=1: write OP_A=0xFFFF_FFFF → PSLVERR=1, o_op_a unchanged; read OP_A in same window → old value, PSLVERR=0.
- Write RESULT=0x1234 → PSLVERR=1, RESULT unchanged.
- i_rst_start=1 coincident with a CTRL write of 0x1 → write rejected with PSLVERR=1, START=0 next cycle.
- Assert ARST during the access phase of OP_B=0xA5 → OP_B stays 0, PSLVERR=0 after reset.
